regfile_debug_port: RTL and testbench

- Debug-side access engine for the integer register file; the external initiator of that file's read and write ports.
- Accepts single-register read/write commands and range-dump commands over a valid/ready command channel.
- Sequences the file's combinational read port (A1/rd1) and its synchronous write port (we/A3/wd).
- Returns results on a valid/ready response stream.
- Sits beside the multicycle core. Accesses the file only while dbg_grant is high; the core is halted and the file port is muxed to this block.

---
 rtl/regfile_debug_port_pkg.sv | 34 +++
 rtl/regfile_debug_port.sv | 168 ++++++++++++++++
 tb/tb_regfile_debug_port.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_debug_port_pkg.sv
// ============================================================================
// regfile_debug_port_pkg : opcodes, FSM encodings and response record shared
//                          by the debug access engine and its environment
// Revision 1.0
// ============================================================================
`default_nettype none

package regfile_debug_port_pkg;

  localparam int CMD_OP_W = 2;

  localparam logic [CMD_OP_W-1:0] OP_READ  = 2'd0;
  localparam logic [CMD_OP_W-1:0] OP_WRITE = 2'd1;
  localparam logic [CMD_OP_W-1:0] OP_DUMP  = 2'd2;
  localparam logic [CMD_OP_W-1:0] OP_RSVD  = 2'd3;

  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE       = 3'd0;
  localparam logic [ST_W-1:0] ST_CHECK      = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT_GRANT = 3'd2;
  localparam logic [ST_W-1:0] ST_READ       = 3'd3;
  localparam logic [ST_W-1:0] ST_WRITE      = 3'd4;
  localparam logic [ST_W-1:0] ST_RESP       = 3'd5;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        err;
    logic        last;
  } rsp_t;

endpackage

`default_nettype wire

// File: rtl/regfile_debug_port.sv
// ============================================================================
// regfile_debug_port : debug initiator for the integer register file; runs
//                      READ / WRITE / DUMP commands onto the rd1 and we ports
// Revision 1.0
// ============================================================================
`default_nettype none

module regfile_debug_port
  import regfile_debug_port_pkg::*;
#(
  parameter int REGISTER_DEPTH = 32,
  parameter int OP_W           = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            dbg_grant,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [4:0]      cmd_addr,
  input  logic [4:0]      cmd_last,
  input  logic [31:0]     cmd_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [4:0]      rsp_addr,
  output logic [31:0]     rsp_data,
  output logic            rsp_err,
  output logic            rsp_last,
  output logic [4:0]      rf_a1,
  input  logic [31:0]     rf_rd1,
  output logic            rf_we,
  output logic [4:0]      rf_a3,
  output logic [31:0]     rf_wd,
  output logic            busy
);

  localparam logic [5:0] DEPTH = 6'(REGISTER_DEPTH);

  logic [ST_W-1:0] state;
  logic [ST_W-1:0] next_state;
  logic [OP_W-1:0] op_q;
  logic [4:0]      cur;
  logic [4:0]      end_idx;
  logic [31:0]     wd_q;
  rsp_t            rsp_q;
  logic            cmd_err;

  // cur holds cmd_addr while in CHECK, so it doubles as the first index here
  always_comb begin
    cmd_err = (op_q == OP_W'(OP_RSVD)) ||
              ({1'b0, cur} >= DEPTH) ||
              ((op_q == OP_W'(OP_DUMP)) &&
               (({1'b0, end_idx} >= DEPTH) || (end_idx < cur)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:       if (cmd_valid) next_state = ST_CHECK;
      ST_CHECK:      next_state = cmd_err ? ST_RESP : ST_WAIT_GRANT;
      ST_WAIT_GRANT: begin
        if (dbg_grant) begin
          next_state = (op_q == OP_W'(OP_WRITE)) ? ST_WRITE : ST_READ;
        end
      end
      ST_READ,
      ST_WRITE:      next_state = dbg_grant ? ST_RESP : ST_WAIT_GRANT;
      ST_RESP: begin
        if (rsp_ready) begin
          next_state = rsp_q.last ? ST_IDLE : ST_WAIT_GRANT;
        end
      end
      default:       next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= '0;
      cur       <= '0;
      end_idx   <= '0;
      wd_q      <= '0;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
      rf_we     <= 1'b0;
      rf_a3     <= '0;
      rf_wd     <= '0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            cur     <= cmd_addr;
            end_idx <= cmd_last;
            wd_q    <= cmd_wdata;
          end
        end
        ST_CHECK: begin
          if (cmd_err) begin
            rsp_q.addr <= cur;
            rsp_q.data <= '0;
            rsp_q.err  <= 1'b1;
            rsp_q.last <= 1'b1;
            rsp_valid  <= 1'b1;
          end
        end
        ST_WAIT_GRANT: begin
          // write strobe is registered so it lines up with the WRITE state; x0 is never written
          if (dbg_grant && (op_q == OP_W'(OP_WRITE))) begin
            rf_we <= (cur != 5'd0);
            rf_a3 <= cur;
            rf_wd <= wd_q;
          end
        end
        ST_READ: begin
          if (dbg_grant) begin
            rsp_q.addr <= cur;
            rsp_q.data <= rf_rd1;
            rsp_q.err  <= 1'b0;
            rsp_q.last <= (op_q == OP_W'(OP_READ)) || (cur == end_idx);
            rsp_valid  <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (dbg_grant) begin
            rsp_q.addr <= cur;
            rsp_q.data <= '0;
            rsp_q.err  <= 1'b0;
            rsp_q.last <= 1'b1;
            rsp_valid  <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!rsp_q.last) begin
              cur <= cur + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign rf_a1    = cur;
  assign rsp_addr = rsp_q.addr;
  assign rsp_data = rsp_q.data;
  assign rsp_err  = rsp_q.err;
  assign rsp_last = rsp_q.last;

endmodule

`default_nettype wire

// File: tb/tb_regfile_debug_port.sv
// ============================================================================
// tb_regfile_debug_port : directed and randomized checks of the debug engine
//                         against a command-level register file model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_regfile_debug_port;
  import regfile_debug_port_pkg::*;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dbg_grant = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = '0;
  logic [4:0]  cmd_addr = '0;
  logic [4:0]  cmd_last = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [4:0]  rsp_addr;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_last;
  logic [4:0]  rf_a1;
  logic [31:0] rf_rd1;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // register file standing in for the real one; pokes preload it
  logic [31:0] file_mem [0:31];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int          we_count = 0;

  // command-level reference
  logic [31:0] model_mem [0:31];
  rsp_t        exp_q [$];
  int          hs_cycles [$];

  regfile_debug_port #(.REGISTER_DEPTH(DEPTH), .OP_W(2)) dut (
    .clk(clk), .reset(reset), .dbg_grant(dbg_grant),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_last(cmd_last), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_last(rsp_last),
    .rf_a1(rf_a1), .rf_rd1(rf_rd1), .rf_we(rf_we), .rf_a3(rf_a3),
    .rf_wd(rf_wd), .busy(busy)
  );

  always #5 clk = ~clk;

  assign rf_rd1 = (rf_a1 == 5'd0) ? 32'd0 : file_mem[rf_a1];

  always @(posedge clk) begin
    if (poke_en) file_mem[poke_idx] <= poke_val;
    else if (rf_we && dbg_grant && rf_a3 != 5'd0) file_mem[rf_a3] <= rf_wd;
    if (rf_we) we_count <= we_count + 1;
  end

  task automatic model_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] l,
                           input logic [31:0] w);
    rsp_t r;
    if (op == OP_RSVD || int'(a) >= DEPTH ||
        (op == OP_DUMP && (int'(l) >= DEPTH || l < a))) begin
      r = '{addr: a, data: 32'd0, err: 1'b1, last: 1'b1};
      exp_q.push_back(r);
    end else if (op == OP_READ) begin
      r = '{addr: a, data: (a == 0) ? 32'd0 : model_mem[a], err: 1'b0, last: 1'b1};
      exp_q.push_back(r);
    end else if (op == OP_WRITE) begin
      if (a != 0) model_mem[a] = w;
      r = '{addr: a, data: 32'd0, err: 1'b0, last: 1'b1};
      exp_q.push_back(r);
    end else begin
      for (int i = int'(a); i <= int'(l); i++) begin
        r = '{addr: 5'(i), data: (i == 0) ? 32'd0 : model_mem[i], err: 1'b0, last: (i == int'(l))};
        exp_q.push_back(r);
      end
    end
  endtask

  task automatic drive_cmd(input logic [1:0] op, input logic [4:0] a, input logic [4:0] l,
                           input logic [31:0] w);
    int t = 0;
    @(negedge clk);
    cmd_op = op; cmd_addr = a; cmd_last = l; cmd_wdata = w; cmd_valid = 1'b1;
    while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
    vectors++;
    if (cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // drains exp_q, checking order, stall stability and one-command-at-a-time
  task automatic collect(input bit rand_ready, input bit rand_grant);
    int   cyc = 0;
    bit   held = 0;
    rsp_t prev, got, e;
    hs_cycles.delete();
    while (exp_q.size() > 0 && cyc < 3000) begin
      @(negedge clk); cyc++;
      if (rand_grant) dbg_grant = ($urandom_range(0, 3) != 0);
      vectors++;
      if (cmd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL cmd_ready_busy: cmd_ready=%b required 0", cmd_ready);
      end
      got = '{addr: rsp_addr, data: rsp_data, err: rsp_err, last: rsp_last};
      rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid === 1'b1) begin
        if (held) begin
          vectors++;
          if (got !== prev) begin
            miscompares++;
            $display("FAIL stall_hold: got %h required %h", got, prev);
          end
        end
        if (rsp_ready) begin
          e = exp_q.pop_front();
          vectors++;
          if (got !== e) begin
            miscompares++;
            $display("FAIL rsp: addr=%0d data=%h err=%b last=%b required addr=%0d data=%h err=%b last=%b",
                     got.addr, got.data, got.err, got.last, e.addr, e.data, e.err, e.last);
          end
          hs_cycles.push_back(cyc);
          held = 0;
        end else begin
          held = 1;
          prev = got;
        end
      end else begin
        held = 0;
      end
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL rsp_timeout: %0d responses outstanding required 0", exp_q.size());
      exp_q.delete();
    end
    dbg_grant = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b1;
    vectors++;
    if ({busy, rsp_valid, cmd_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL idle_after: busy,rsp_valid,cmd_ready=%b required 001", {busy, rsp_valid, cmd_ready});
    end
  endtask

  task automatic check_reset_values(input string tag);
    vectors++;
    if ({cmd_ready, busy, rsp_valid, rsp_err, rsp_last, rsp_addr, rsp_data,
         rf_we, rf_a1, rf_a3, rf_wd} !== {1'b1, 1'b0, 3'b000, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL %s: rdy=%b busy=%b v=%b err=%b last=%b addr=%0d data=%h we=%b a1=%0d a3=%0d wd=%h required rdy=1 rest 0",
               tag, cmd_ready, busy, rsp_valid, rsp_err, rsp_last, rsp_addr, rsp_data, rf_we, rf_a1, rf_a3, rf_wd);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset_state");
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      poke_en = 1'b1; poke_idx = 5'(i);
      poke_val = (i == 5) ? 32'hDEAD_BEEF : $urandom;
      model_mem[i] = poke_val;
    end
    model_mem[0] = 32'd0;
    @(negedge clk);
    poke_en = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_read_latency();
    int lat = 1;
    rsp_ready = 1'b0;
    model_cmd(OP_READ, 5'd5, 5'd0, 32'd0);
    drive_cmd(OP_READ, 5'd5, 5'd0, 32'd0);
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    vectors++;
    if (lat != 4) begin
      miscompares++;
      $display("FAIL read_latency: rsp_valid at cycle %0d required 4", lat);
    end
    collect(1'b0, 1'b0);
  endtask

  task automatic test_write();
    int lat = 1;
    int we0;
    rsp_ready = 1'b0;
    we0 = we_count;
    model_cmd(OP_WRITE, 5'd7, 5'd0, 32'h1234_5678);
    drive_cmd(OP_WRITE, 5'd7, 5'd0, 32'h1234_5678);
    while (!rf_we && lat < 20) begin @(negedge clk); lat++; end
    vectors++;
    if (lat != 3 || rf_a3 !== 5'd7 || rf_wd !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL write_strobe: cycle=%0d a3=%0d wd=%h required cycle=3 a3=7 wd=12345678", lat, rf_a3, rf_wd);
    end
    collect(1'b0, 1'b0);
    vectors++;
    if (we_count - we0 != 1) begin
      miscompares++;
      $display("FAIL write_pulses: %0d required 1", we_count - we0);
    end
    model_cmd(OP_READ, 5'd7, 5'd0, 32'd0);
    drive_cmd(OP_READ, 5'd7, 5'd0, 32'd0);
    collect(1'b0, 1'b0);
    we0 = we_count;
    model_cmd(OP_WRITE, 5'd0, 5'd0, 32'hFFFF_FFFF);
    drive_cmd(OP_WRITE, 5'd0, 5'd0, 32'hFFFF_FFFF);
    collect(1'b0, 1'b0);
    model_cmd(OP_READ, 5'd0, 5'd0, 32'd0);
    drive_cmd(OP_READ, 5'd0, 5'd0, 32'd0);
    collect(1'b0, 1'b0);
    vectors++;
    if (we_count != we0) begin
      miscompares++;
      $display("FAIL write_x0_pulses: %0d required 0", we_count - we0);
    end
  endtask

  task automatic test_dump();
    model_cmd(OP_DUMP, 5'd10, 5'd13, 32'd0);
    drive_cmd(OP_DUMP, 5'd10, 5'd13, 32'd0);
    collect(1'b1, 1'b0);
    vectors++;
    if (hs_cycles.size() != 4) begin
      miscompares++;
      $display("FAIL dump_count: %0d responses required 4", hs_cycles.size());
    end
    model_cmd(OP_DUMP, 5'd2, 5'd5, 32'd0);
    drive_cmd(OP_DUMP, 5'd2, 5'd5, 32'd0);
    collect(1'b0, 1'b0);
    for (int i = 1; i < hs_cycles.size(); i++) begin
      vectors++;
      if (hs_cycles[i] - hs_cycles[i-1] != 3) begin
        miscompares++;
        $display("FAIL dump_spacing: %0d cycles required 3", hs_cycles[i] - hs_cycles[i-1]);
      end
    end
  endtask

  task automatic test_errors();
    int we0 = we_count;
    logic [1:0]  ops [5] = '{OP_RSVD, OP_DUMP, OP_READ, OP_DUMP, OP_WRITE};
    logic [4:0]  as  [5] = '{5'd3, 5'd9, 5'd20, 5'd3, 5'd16};
    logic [4:0]  ls  [5] = '{5'd3, 5'd4, 5'd0, 5'd16, 5'd0};
    for (int i = 0; i < 5; i++) begin
      model_cmd(ops[i], as[i], ls[i], 32'hA5A5_A5A5);
      drive_cmd(ops[i], as[i], ls[i], 32'hA5A5_A5A5);
      collect(1'b1, 1'b0);
    end
    vectors++;
    if (we_count != we0) begin
      miscompares++;
      $display("FAIL error_writes: %0d pulses required 0", we_count - we0);
    end
  endtask

  task automatic test_grant_wait();
    int we0 = we_count;
    logic [31:0] w = $urandom;
    dbg_grant = 1'b0;
    model_cmd(OP_WRITE, 5'd9, 5'd0, w);
    drive_cmd(OP_WRITE, 5'd9, 5'd0, w);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vectors++;
      if ({rf_we, rsp_valid, busy} !== 3'b001) begin
        miscompares++;
        $display("FAIL grant_wait: we,rsp_valid,busy=%b required 001", {rf_we, rsp_valid, busy});
      end
    end
    dbg_grant = 1'b1;
    collect(1'b0, 1'b0);
    vectors++;
    if (we_count - we0 != 1) begin
      miscompares++;
      $display("FAIL grant_write_pulses: %0d required 1", we_count - we0);
    end
    model_cmd(OP_READ, 5'd9, 5'd0, 32'd0);
    drive_cmd(OP_READ, 5'd9, 5'd0, 32'd0);
    collect(1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_dump();
    int t = 0;
    rsp_ready = 1'b0;
    drive_cmd(OP_DUMP, 5'd0, 5'd15, 32'd0);
    while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
    vectors++;
    if (rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_dump_resp: rsp_valid=%b required 1", rsp_valid);
    end
    reset = 1'b1;
    #1;
    check_reset_values("reset_async");
    @(negedge clk);
    reset = 1'b0;
    rsp_ready = 1'b1;
    model_cmd(OP_READ, 5'd5, 5'd0, 32'd0);
    drive_cmd(OP_READ, 5'd5, 5'd0, 32'd0);
    collect(1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [4:0]  a, l;
    logic [31:0] w;
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 9) < 9 ? $urandom_range(0, 2) : 3);
      a  = 5'($urandom_range(0, 17));
      l  = (op == OP_DUMP) ? 5'(int'(a) + $urandom_range(0, 4) - 1) : 5'($urandom);
      w  = $urandom;
      if (op == OP_DUMP && a == 0 && l == 5'd31) l = 5'd2;
      model_cmd(op, a, l, w);
      drive_cmd(op, a, l, w);
      collect(1'b1, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_read_latency();
    test_write();
    test_dump();
    test_errors();
    test_grant_wait();
    test_reset_mid_dump();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
